// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: start/busy/done handshake and data bus of the sequential
// multiplier.
//   start   : request from the master, sampled by the multiplier only when idle
//   a, b    : multiplicand / multiplier, signed two's complement
//   busy    : iteration in progress
//   done    : one-cycle pulse, product/zr/ng valid
//   product : low WIDTH bits of a*b, held until the next done
//   zr, ng  : product == 0, product sign bit
interface alu_mul_seq_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             zr;
  logic             ng;

  modport master (output start, a, b, input busy, done, product, zr, ng);
  modport slave  (input start, a, b, output busy, done, product, zr, ng);
endinterface

// File: rtl/alu_mul_seq.sv
// alu: combinational 16-bit ALU with the six-bit zx/nx/zy/ny/f/no control
// scheme.
//   x_i, y_i     : operands
//   zx_i .. no_i : zero/negate x, zero/negate y, function (1 = add, 0 = and),
//                  negate output
//   out_o        : result
//   zr_o, ng_o   : out_o == 0, out_o sign bit
module alu (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic        zx_i,
  input  logic        nx_i,
  input  logic        zy_i,
  input  logic        ny_i,
  input  logic        f_i,
  input  logic        no_i,
  output logic [15:0] out_o,
  output logic        zr_o,
  output logic        ng_o
);
  logic [15:0] x_z, x_n, y_z, y_n, f_out;

  assign x_z   = zx_i ? 16'h0000 : x_i;
  assign x_n   = nx_i ? ~x_z : x_z;
  assign y_z   = zy_i ? 16'h0000 : y_i;
  assign y_n   = ny_i ? ~y_z : y_z;
  assign f_out = f_i ? (x_n + y_n) : (x_n & y_n);
  assign out_o = no_i ? ~f_out : f_out;
  assign zr_o  = (out_o == 16'h0000);
  assign ng_o  = out_o[15];
endmodule

// alu_mul_seq: multi-cycle shift-and-add multiplier that sequences a single
// ALU instance, alternating between the accumulate step and the
// multiplicand-doubling step. Fixed 34-cycle turnaround, including DONE and
// the following idle cycle.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset; aborts any operation in flight
//   bus   : slave side of alu_mul_seq_if (start/a/b in, busy/done/product/zr/ng out)
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start; operands captured on acceptance
// S_ADD   | acc += mcand when the current multiplier bit is set
// S_SHIFT | mcand doubled through the ALU, mplier >>= 1, count++
// S_DONE  | product/zr/ng latched from acc, done pulsed on the next cycle
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_mul_seq_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [3:0]       count_q, count_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] alu_x, alu_y, alu_out;
  logic             alu_zr, alu_ng;
  logic             unused_alu_flags;

  // Control bits tied to x+y; sequencing is done purely through the operand muxes.
  alu u_alu (
    .x_i   (alu_x),
    .y_i   (alu_y),
    .zx_i  (1'b0),
    .nx_i  (1'b0),
    .zy_i  (1'b0),
    .ny_i  (1'b0),
    .f_i   (1'b1),
    .no_i  (1'b0),
    .out_o (alu_out),
    .zr_o  (alu_zr),
    .ng_o  (alu_ng)
  );

  assign unused_alu_flags = alu_zr ^ alu_ng;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;
    zr_d      = zr_q;
    ng_d      = ng_q;
    done_d    = 1'b0;
    alu_x     = acc_q;
    alu_y     = mcand_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d    = '0;
          mcand_d  = bus.a;
          mplier_d = bus.b;
          count_d  = 4'd0;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        if (mplier_q[0]) acc_d = alu_out;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // mcand + mcand == mcand << 1
        alu_x    = mcand_q;
        alu_y    = mcand_q;
        mcand_d  = alu_out;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 4'd1;
        state_d  = (count_q == 4'd15) ? S_DONE : S_ADD;
      end
      S_DONE: begin
        product_d = acc_q;
        zr_d      = (acc_q == '0);
        ng_d      = acc_q[WIDTH-1];
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= 4'd0;
      product_q <= '0;
      zr_q      <= 1'b0;
      ng_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
      zr_q      <= zr_d;
      ng_q      <= ng_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = (state_q == S_ADD) || (state_q == S_SHIFT);
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.zr      = zr_q;
  assign bus.ng      = ng_q;
endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle 16-bit shift-and-add multiplier built around one internal instance of the team's combinational ALU module.
- The block is the ALU's sequencer: it owns the ALU's x/y operand muxes and its six control bits (zx,nx,zy,ny,f,no), and time-shares the single ALU between the accumulate step and the multiplicand-doubling step.
- Produces the low 16 bits of the two's-complement product plus zero/negative flags, using a start/busy/done handshake.
- Sits beside the CPU datapath as a coprocessor for a MUL operation that the base ALU lacks.

Parameters:
- WIDTH, 16, operand/result width. Fixed at 16 to match the ALU; no other value is supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- a  input  16  multiplicand, signed two's complement; captured when start is accepted.
- b  input  16  multiplier, signed two's complement; captured when start is accepted.
- busy  output  1  high from the cycle after acceptance through the last iteration cycle.
- done  output  1  single-cycle pulse; product is valid.
- product  output  16  low 16 bits of a*b; held until the next done.
- zr  output  1  product == 0; registered together with product.
- ng  output  1  product[15]; registered together with product.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, product=0, zr=0, ng=0; internal acc, mcand, mplier and count are cleared.
- Reset mid-operation aborts the operation: no done pulse is issued and product returns to 0.
- Internal registers: acc[15:0], mcand[15:0], mplier[15:0], count[3:0].
- Single ALU instance with fixed control bits zx=0, nx=0, zy=0, ny=0, f=1, no=0 (x+y). The ALU zr/ng outputs are not used.
- Operand muxing:
  - In ADD: x=acc, y=mcand.
  - In SHIFT: x=mcand, y=mcand, so the ALU output is mcand<<1.
  - In other states the operands are don't-care.
- States and transitions:
  - IDLE: busy=0. If start=1: acc<=0, mcand<=a, mplier<=b, count<=0, go to ADD.
  - ADD: busy=1. If mplier[0]=1, acc<=ALU out; else acc is held. Go to SHIFT.
  - SHIFT: busy=1. mcand<=ALU out; mplier<=mplier>>1 (logical shift); count<=count+1. If count==15, go to DONE; else go to ADD.
  - DONE: busy=0. product<=acc, zr<=(acc==0), ng<=acc[15], done<=1 for this cycle only. Go to IDLE.
- Latency: fixed. If start is sampled at edge T, done is high in the cycle after edge T+33 (16 iterations × 2 cycles + 1 DONE cycle). This does not depend on the data.
- Throughput: a new start can be accepted in the cycle immediately after done (IDLE), giving one result per 34 cycles.
- start while busy or in DONE is ignored, not queued. a and b may change freely after acceptance.
- Arithmetic: all adds wrap modulo 2^16 with no overflow flag. The low 16 bits of the signed product equal the low 16 bits of the unsigned product, so no sign correction is needed.
- zr and ng reflect only the latched product, never intermediate values.

Test Plan:
- Reset, then a=3, b=5, start pulsed 1 cycle -> busy=1 for 32 cycles; done pulses exactly once, 33 cycles after acceptance; product=15 (0x000F), zr=0, ng=0.
- a=-3, b=7 -> product=-21 (0xFFEB), ng=1, zr=0. Also a=-1, b=-1 -> product=1 (0x0001).
- a=0x0100, b=0x0100 (true product 0x10000) -> product=0x0000, zr=1, ng=0 (wrap). Also a=0x7FFF, b=2 -> product=0xFFFE, ng=1.
- start held high continuously from the first acceptance with a=2, b=3, and operands changed to a=4, b=5 after 2 cycles -> first done gives 6 after 33 cycles; the next acceptance occurs in the IDLE cycle right after done; second done gives 20 a further 34 cycles later. No extra done pulses.
- Start a=9, b=9, drive rst_n=0 for one edge at cycle 10 of the operation -> busy=0, product=0, no done pulse. Then a fresh a=9, b=9 request -> product=81 (0x0051).
- Let a prior product be nonzero, then start a=0, b=0x1234 -> the old product is held until done; done then delivers product=0, zr=1.
